ita_tcdm_prio_arbiter: RTL

- Parametrised N-channel TCDM load/store arbiter for the ITA HWPE streamer. Successor to the fixed 4-channel out-of-order mux plus response-ID filter.
- Merges NB_CHAN initiator request channels (input, weight, bias, output, ...) onto one TCDM port.
- Arbitrates by runtime-programmable static priority, with starvation aging.
- Routes in-order read responses back through an internal grant-order FIFO, so no TCDM-side ID is needed.

---
 rtl/ita_tcdm_prio_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ita_tcdm_prio_arbiter.sv
// ita_tcdm_prio_arbiter
// Merges NB_CHAN initiator request channels onto a single TCDM port.
// Arbitration uses runtime-programmable static priority with starvation aging.
// In-order read responses are steered back through a grant-order FIFO, so the
// TCDM side needs no transaction ID.
//
// Optional feature: define ITA_TCDM_ARB_PERF_EN to add per-channel 32-bit
// grant counters. In the default build these are absent and grant_cnt_o is 0.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   clear_i                  synchronous clear of all state
//   enable_i                 arbitration enable
//   priority_i               per-channel priority (slice c = channel c, higher wins)
//   in_req/gnt/wen/add/be/data  initiator request channels
//   in_r_valid_o/in_r_data_o    read response (data broadcast)
//   out_*                    TCDM port (request + in-order response)
//   busy_o                   reads outstanding
//   err_o                    sticky: response with no read outstanding
//   grant_cnt_o              per-channel grant counters (perf build only)
module ita_tcdm_prio_arbiter #(
  parameter int unsigned NB_CHAN    = 4,
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 32,
  parameter int unsigned BW         = 8,
  parameter int unsigned STARVE_MAX = 15,
  parameter int unsigned RSP_DEPTH  = 4,
  parameter int unsigned CW         = $clog2(NB_CHAN)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        enable_i,
  input  logic [NB_CHAN*CW-1:0]       priority_i,
  input  logic [NB_CHAN-1:0]          in_req_i,
  output logic [NB_CHAN-1:0]          in_gnt_o,
  input  logic [NB_CHAN-1:0]          in_wen_i,
  input  logic [NB_CHAN*AW-1:0]       in_add_i,
  input  logic [NB_CHAN*(DW/BW)-1:0]  in_be_i,
  input  logic [NB_CHAN*DW-1:0]       in_data_i,
  output logic [NB_CHAN-1:0]          in_r_valid_o,
  output logic [DW-1:0]               in_r_data_o,
  output logic                        out_req_o,
  input  logic                        out_gnt_i,
  output logic                        out_wen_o,
  output logic [AW-1:0]               out_add_o,
  output logic [DW/BW-1:0]            out_be_o,
  output logic [DW-1:0]               out_data_o,
  input  logic                        out_r_valid_i,
  input  logic [DW-1:0]               out_r_data_i,
  output logic                        busy_o,
  output logic                        err_o,
  output logic [NB_CHAN*32-1:0]       grant_cnt_o
);

  localparam int unsigned BEW = DW / BW;
  localparam int unsigned PW  = $clog2(RSP_DEPTH);
  localparam int unsigned SW  = 8;
  localparam logic [SW-1:0] SMAX  = STARVE_MAX[SW-1:0];
  localparam logic [PW:0]   DEPTH = RSP_DEPTH[PW:0];
  localparam logic [PW:0]   ONE_C = 1;
  localparam logic [PW-1:0] ONE_P = 1;

  logic [NB_CHAN-1:0] eligible;
  logic               any_elig, transfer, full, empty, push, pop;
  logic               starve_hit, prio_found;
  logic [CW-1:0]      winner, best_prio, head;
  logic [SW-1:0]      starve_q [NB_CHAN];
  logic [CW-1:0]      fifo_q   [RSP_DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PW:0]        cnt_q;
  logic               err_q;

  assign full  = (cnt_q == DEPTH);
  assign empty = (cnt_q == '0);

  // A full FIFO blocks reads even when a pop happens this cycle; this keeps
  // eligibility independent of the response path.
  always_comb begin
    eligible = '0;
    for (int c = 0; c < NB_CHAN; c++)
      eligible[c] = in_req_i[c] & enable_i & (~in_wen_i[c] | ~full);
  end

  // Starved channels take precedence (lowest index first); otherwise the
  // highest priority wins, ties to the lowest index via strict compare.
  always_comb begin
    winner     = '0;
    best_prio  = '0;
    starve_hit = 1'b0;
    prio_found = 1'b0;
    for (int c = NB_CHAN - 1; c >= 0; c--) begin
      if (eligible[c] && starve_q[c] == SMAX) begin
        winner     = CW'(c);
        starve_hit = 1'b1;
      end
    end
    if (!starve_hit) begin
      for (int c = 0; c < NB_CHAN; c++) begin
        if (eligible[c] && (!prio_found || priority_i[c*CW +: CW] > best_prio)) begin
          winner     = CW'(c);
          best_prio  = priority_i[c*CW +: CW];
          prio_found = 1'b1;
        end
      end
    end
  end

  assign any_elig   = |eligible;
  assign transfer   = any_elig & out_gnt_i;
  assign out_req_o  = any_elig;
  assign out_wen_o  = in_wen_i[winner];
  assign out_add_o  = in_add_i[winner*AW +: AW];
  assign out_be_o   = in_be_i[winner*BEW +: BEW];
  assign out_data_o = in_data_i[winner*DW +: DW];

  always_comb begin
    in_gnt_o         = '0;
    in_gnt_o[winner] = transfer;
  end

  assign push = transfer & in_wen_i[winner];
  assign pop  = out_r_valid_i & ~empty;
  assign head = fifo_q[rd_ptr_q];

  always_comb begin
    in_r_valid_o = '0;
    if (pop) in_r_valid_o[head] = 1'b1;
  end

  assign in_r_data_o = out_r_data_i;
  assign busy_o      = ~empty;
  assign err_o       = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= winner;
        wr_ptr_q         <= wr_ptr_q + ONE_P;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + ONE_P;
      if (push && !pop)      cnt_q <= cnt_q + ONE_C;
      else if (pop && !push) cnt_q <= cnt_q - ONE_C;
      if (out_r_valid_i && empty) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NB_CHAN; c++) starve_q[c] <= '0;
    end else if (clear_i) begin
      for (int c = 0; c < NB_CHAN; c++) starve_q[c] <= '0;
    end else if (enable_i) begin
      for (int c = 0; c < NB_CHAN; c++) begin
        if (!in_req_i[c])
          starve_q[c] <= '0;
        else if (transfer && winner == CW'(c))
          starve_q[c] <= '0;
        else if (eligible[c] && transfer && starve_q[c] != SMAX)
          starve_q[c] <= starve_q[c] + 8'd1;
      end
    end
  end

`ifdef ITA_TCDM_ARB_PERF_EN
  logic [31:0] gcnt_q [NB_CHAN];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NB_CHAN; c++) gcnt_q[c] <= '0;
    end else if (clear_i) begin
      for (int c = 0; c < NB_CHAN; c++) gcnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < NB_CHAN; c++)
        if (transfer && winner == CW'(c)) gcnt_q[c] <= gcnt_q[c] + 32'd1;
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int c = 0; c < NB_CHAN; c++) grant_cnt_o[c*32 +: 32] = gcnt_q[c];
  end
`else
  assign grant_cnt_o = '0;
`endif

endmodule
